// File: rtl/fetch_decode_stage.sv
// LEGv8 instruction-fetch stage with IF/ID pipeline register.
// Fetches over a req/valid handshake and absorbs one in-flight word in a skid buffer while stalled.
module fetch_decode_stage #(
  parameter int                  PC_WIDTH    = 64,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  CNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   imem_valid,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   id_valid,
  output logic [PC_WIDTH-1:0]    id_pc,
  output logic [INSTR_WIDTH-1:0] id_instr,
  output logic [10:0]            opcode,
  output logic [CNT_WIDTH-1:0]   fetch_count
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t                 r_state;
  logic                   r_imem_req;
  logic [PC_WIDTH-1:0]    r_pc;
  logic                   r_id_valid;
  logic [PC_WIDTH-1:0]    r_id_pc;
  logic [INSTR_WIDTH-1:0] r_id_instr;
  logic [PC_WIDTH-1:0]    r_skid_pc;
  logic [INSTR_WIDTH-1:0] r_skid_instr;
  logic [CNT_WIDTH-1:0]   r_count;

  logic [PC_WIDTH-1:0]    w_target;
  logic [PC_WIDTH-1:0]    w_pc_inc;
  logic [CNT_WIDTH-1:0]   w_count_inc;

  assign w_target    = branch_target & ~PC_WIDTH'(3);
  assign w_pc_inc    = r_pc + PC_WIDTH'(4);
  assign w_count_inc = r_count + CNT_WIDTH'(1);

  // Redirect outranks everything; in HOLD the PC already points past the skid word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_imem_req   <= 1'b0;
      r_pc         <= RESET_PC;
      r_id_valid   <= 1'b0;
      r_id_pc      <= '0;
      r_id_instr   <= '0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
      r_count      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= FETCH;
          r_imem_req <= 1'b1;
        end
        FETCH: begin
          if (branch_taken) begin
            r_pc         <= w_target;
            r_id_valid   <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
          end else if (imem_valid && !stall) begin
            r_id_pc    <= r_pc;
            r_id_instr <= imem_rdata;
            r_id_valid <= 1'b1;
            r_pc       <= w_pc_inc;
            r_count    <= w_count_inc;
          end else if (imem_valid && stall) begin
            r_skid_pc    <= r_pc;
            r_skid_instr <= imem_rdata;
            r_pc         <= w_pc_inc;
            r_state      <= HOLD;
            r_imem_req   <= 1'b0;
          end else if (!stall) begin
            r_id_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            r_pc         <= w_target;
            r_id_valid   <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_state      <= FETCH;
            r_imem_req   <= 1'b1;
          end else if (!stall) begin
            r_id_pc      <= r_skid_pc;
            r_id_instr   <= r_skid_instr;
            r_id_valid   <= 1'b1;
            r_count      <= w_count_inc;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_state      <= FETCH;
            r_imem_req   <= 1'b1;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign id_valid    = r_id_valid;
  assign id_pc       = r_id_pc;
  assign id_instr    = r_id_instr;
  assign opcode      = r_id_valid ? r_id_instr[31:21] : 11'b0;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed self-checking bench for fetch_decode_stage with a combinational instruction memory.
// Built with a 4-bit fetch counter so the wrap is reachable in a few cycles.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic [10:0] opcode;
  logic [3:0]  fetch_count;
  logic        memEn = 1'b1;

  int nCompared = 0;
  int nMismatched = 0;

  fetch_decode_stage #(
    .PC_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(64'h0), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .opcode(opcode), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [63:0] a);
    case (a)
      64'h0:   memWord = 32'h8B020020;
      64'h4:   memWord = 32'h91000421;
      default: memWord = 32'hA000_0000 + a[31:0];
    endcase
  endfunction

  assign imem_rdata = memWord(imem_addr);
  assign imem_valid = memEn;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; memEn = 1'b1; stall = 1'b0; branch_taken = 1'b0;
    tick();
    nCompared++; if (imem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_req: got %0h want 0", imem_req); end
    nCompared++; if (id_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_id_valid: got %0h want 0", id_valid); end
    nCompared++; if (id_pc !== 64'h0 || id_instr !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_ifid: got pc %0h instr %0h want 0 0", id_pc, id_instr); end
    nCompared++; if (opcode !== 11'h0 || fetch_count !== 4'h0 || imem_addr !== 64'h0) begin nMismatched++; $display("[TB] FAIL reset_misc: got op %0h cnt %0h addr %0h want 0 0 0", opcode, fetch_count, imem_addr); end
    rst_n = 1'b1;
    tick();
    nCompared++; if (imem_req !== 1'b1 || id_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_to_fetch: got req %0h vld %0h want 1 0", imem_req, id_valid); end
    tick();
    nCompared++; if (id_valid !== 1'b1 || id_pc !== 64'h0 || opcode !== 11'b100_0101_1000) begin nMismatched++; $display("[TB] FAIL first_fetch: got vld %0h pc %0h op %0h want 1 0 458", id_valid, id_pc, opcode); end
    tick();
    nCompared++; if (id_pc !== 64'h4 || opcode !== 11'b100_1000_1000 || id_instr !== 32'h91000421) begin nMismatched++; $display("[TB] FAIL second_fetch: got pc %0h op %0h instr %0h want 4 488 91000421", id_pc, opcode, id_instr); end
    nCompared++; if (fetch_count !== 4'd2 || imem_addr !== 64'h8) begin nMismatched++; $display("[TB] FAIL count_after_two: got cnt %0d addr %0h want 2 8", fetch_count, imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      nCompared++; if (id_pc !== 64'h4 || id_valid !== 1'b1 || imem_req !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_hold_%0d: got pc %0h vld %0h req %0h want 4 1 0", i, id_pc, id_valid, imem_req); end
      nCompared++; if (fetch_count !== 4'd2 || imem_addr !== 64'hC) begin nMismatched++; $display("[TB] FAIL stall_cnt_%0d: got cnt %0d addr %0h want 2 c", i, fetch_count, imem_addr); end
    end
    stall = 1'b0;
    tick();
    nCompared++; if (id_pc !== 64'h8 || id_instr !== 32'hA0000008 || opcode !== 11'h500) begin nMismatched++; $display("[TB] FAIL skid_release: got pc %0h instr %0h op %0h want 8 a0000008 500", id_pc, id_instr, opcode); end
    nCompared++; if (fetch_count !== 4'd3 || imem_req !== 1'b1 || imem_addr !== 64'hC) begin nMismatched++; $display("[TB] FAIL skid_release_state: got cnt %0d req %0h addr %0h want 3 1 c", fetch_count, imem_req, imem_addr); end
    tick();
    nCompared++; if (id_pc !== 64'hC || fetch_count !== 4'd4) begin nMismatched++; $display("[TB] FAIL after_stall: got pc %0h cnt %0d want c 4", id_pc, fetch_count); end
  endtask

  task automatic test_bubble();
    memEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nCompared++; if (id_valid !== 1'b0 || opcode !== 11'h0 || imem_addr !== 64'h10 || fetch_count !== 4'd4) begin nMismatched++; $display("[TB] FAIL bubble_%0d: got vld %0h op %0h addr %0h cnt %0d want 0 0 10 4", i, id_valid, opcode, imem_addr, fetch_count); end
    end
    memEn = 1'b1;
    tick();
    nCompared++; if (id_valid !== 1'b1 || id_pc !== 64'h10 || fetch_count !== 4'd5) begin nMismatched++; $display("[TB] FAIL bubble_resume: got vld %0h pc %0h cnt %0d want 1 10 5", id_valid, id_pc, fetch_count); end
  endtask

  task automatic test_branch_stalled();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h103;
    tick();
    nCompared++; if (id_valid !== 1'b0 || imem_addr !== 64'h100 || fetch_count !== 4'd5 || imem_req !== 1'b1) begin nMismatched++; $display("[TB] FAIL branch_stalled: got vld %0h addr %0h cnt %0d req %0h want 0 100 5 1", id_valid, imem_addr, fetch_count, imem_req); end
    stall = 1'b0; branch_taken = 1'b0;
    tick();
    nCompared++; if (id_pc !== 64'h100 || id_valid !== 1'b1 || fetch_count !== 4'd6) begin nMismatched++; $display("[TB] FAIL branch_target_fetch: got pc %0h vld %0h cnt %0d want 100 1 6", id_pc, id_valid, fetch_count); end
  endtask

  task automatic test_branch_in_hold();
    stall = 1'b1;
    tick();
    nCompared++; if (imem_req !== 1'b0 || imem_addr !== 64'h108) begin nMismatched++; $display("[TB] FAIL enter_hold: got req %0h addr %0h want 0 108", imem_req, imem_addr); end
    branch_taken = 1'b1; branch_target = 64'h202;
    tick();
    nCompared++; if (id_valid !== 1'b0 || imem_addr !== 64'h200 || imem_req !== 1'b1 || fetch_count !== 4'd6) begin nMismatched++; $display("[TB] FAIL hold_branch: got vld %0h addr %0h req %0h cnt %0d want 0 200 1 6", id_valid, imem_addr, imem_req, fetch_count); end
    branch_taken = 1'b0; stall = 1'b0;
    tick();
    nCompared++; if (id_pc !== 64'h200 || id_instr !== 32'hA0000200 || fetch_count !== 4'd7) begin nMismatched++; $display("[TB] FAIL hold_branch_fetch: got pc %0h instr %0h cnt %0d want 200 a0000200 7", id_pc, id_instr, fetch_count); end
  endtask

  task automatic test_reset_mid_hold();
    stall = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    nCompared++; if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_pc !== 64'h0 || id_instr !== 32'h0) begin nMismatched++; $display("[TB] FAIL async_reset_ifid: got req %0h vld %0h pc %0h instr %0h want 0 0 0 0", imem_req, id_valid, id_pc, id_instr); end
    nCompared++; if (fetch_count !== 4'd0 || imem_addr !== 64'h0 || opcode !== 11'h0) begin nMismatched++; $display("[TB] FAIL async_reset_misc: got cnt %0d addr %0h op %0h want 0 0 0", fetch_count, imem_addr, opcode); end
    stall = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    nCompared++; if (id_pc !== 64'h0 || id_valid !== 1'b1 || fetch_count !== 4'd1 || id_instr !== 32'h8B020020) begin nMismatched++; $display("[TB] FAIL resume_after_reset: got pc %0h vld %0h cnt %0d instr %0h want 0 1 1 8b020020", id_pc, id_valid, fetch_count, id_instr); end
  endtask

  task automatic test_pc_wrap();
    branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    nCompared++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC || id_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrap_redirect: got addr %0h vld %0h want fffffffffffffffc 0", imem_addr, id_valid); end
    tick();
    nCompared++; if (imem_addr !== 64'h0 || id_pc !== 64'hFFFF_FFFF_FFFF_FFFC || id_instr !== 32'h9FFFFFFC) begin nMismatched++; $display("[TB] FAIL pc_wrap: got addr %0h pc %0h instr %0h want 0 fffffffffffffffc 9ffffffc", imem_addr, id_pc, id_instr); end
    tick();
    nCompared++; if (fetch_count !== 4'd3 || id_pc !== 64'h0) begin nMismatched++; $display("[TB] FAIL after_wrap: got cnt %0d pc %0h want 3 0", fetch_count, id_pc); end
  endtask

  task automatic test_count_wrap();
    for (int i = 0; i < 12; i++) tick();
    nCompared++; if (fetch_count !== 4'hF) begin nMismatched++; $display("[TB] FAIL count_max: got %0d want 15", fetch_count); end
    tick();
    nCompared++; if (fetch_count !== 4'h0 || id_valid !== 1'b1 || id_pc !== 64'h34) begin nMismatched++; $display("[TB] FAIL count_wrap: got cnt %0d vld %0h pc %0h want 0 1 34", fetch_count, id_valid, id_pc); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_bubble();
    test_branch_stalled();
    test_branch_in_hold();
    test_reset_mid_hold();
    test_pc_wrap();
    test_count_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the LEGv8 core.
- Holds the PC and fetches 32-bit words over a request/valid instruction-memory handshake.
- Latches instruction and PC into the IF/ID register and drives the 11-bit opcode consumed directly by ControlUnit.
- Handles pipeline stall, taken-branch redirect/squash, and keeps a retired-fetch counter for bring-up.

Parameters:
- PC_WIDTH, 64: width of PC, addresses, branch target.
- INSTR_WIDTH, 32: instruction word width.
- RESET_PC, 64'h0: PC value loaded on reset.
- CNT_WIDTH, 32: width of fetch_count.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request; imem_addr valid while high.
- imem_addr  output  PC_WIDTH  byte address of word requested; always current PC, [1:0]=00.
- imem_rdata  input  INSTR_WIDTH  fetched word; qualified by imem_valid.
- imem_valid  input  1  imem_rdata holds the word for the imem_addr presented this cycle.
- stall  input  1  hazard unit: ID must hold its current instruction.
- branch_taken  input  1  redirect request from branch resolution.
- branch_target  input  PC_WIDTH  redirect address; bits [1:0] ignored, forced 00.
- id_valid  output  1  IF/ID register holds a live instruction.
- id_pc  output  PC_WIDTH  PC of the IF/ID instruction.
- id_instr  output  INSTR_WIDTH  IF/ID instruction word.
- opcode  output  11  id_valid ? id_instr[31:21] : 11'b0; feeds ControlUnit.
- fetch_count  output  CNT_WIDTH  instructions loaded into IF/ID, wraps.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE.
  - id_valid=0, id_pc=0, id_instr=0, opcode=0.
  - skid buffer empty, fetch_count=0, imem_req=0.
  - Reset asserted mid-operation clears all state immediately; no memory response is honoured afterwards.
- FSM states: IDLE, FETCH, HOLD.
- IDLE:
  - imem_req=0.
  - First clock edge after rst_n deasserts -> FETCH.
  - IF/ID stays invalid.
- FETCH: imem_req=1, imem_addr=pc. Each edge:
  - imem_valid & !stall: IF/ID <= {pc, imem_rdata}, id_valid<=1, pc<=pc+4, fetch_count+1; remain FETCH.
  - imem_valid & stall: IF/ID unchanged; skid <= {pc, imem_rdata}; pc<=pc+4; -> HOLD.
  - !imem_valid & !stall: id_valid<=0 (bubble), pc unchanged.
  - !imem_valid & stall: nothing changes.
- HOLD:
  - imem_req=0; IF/ID unchanged.
  - Leaving HOLD: when stall=0, IF/ID <= skid, id_valid<=1, fetch_count+1, skid cleared -> FETCH.
- Redirect:
  - branch_taken on any edge in FETCH or HOLD has top priority over stall and imem_valid.
  - pc <= {branch_target[PC_WIDTH-1:2],2'b00}; id_valid<=0; skid cleared.
  - Any same-cycle imem response is discarded; fetch_count unchanged; -> FETCH.
  - branch_taken in IDLE is ignored.
- Output timing: id_* and opcode change only on clock edges (registered), except opcode is a pure function of IF/ID register contents.
- PC arithmetic is modulo 2^PC_WIDTH: pc=all-ones-minus-3 increments to 0.
- fetch_count wraps to 0 after all-ones.
- The IF/ID register is consumed by ID on every edge where stall=0.

Test Plan:
- Reset release, memory always valid returning 32'h8B020020 at 0, 32'h91000421 at 4:
  - Expected: imem_req rises one cycle after rst_n; id_pc 0 then 4.
  - Expected: opcode 11'b100_0101_1000 then 11'b100_1000_1000; fetch_count=2.
- Stall asserted 2 cycles while word at 8 returns:
  - Expected: IF/ID holds pc 4; state HOLD with imem_req=0.
  - Expected: after stall drops, id_pc=8 with no word lost or duplicated; next fetch addr 12.
- imem_valid low 3 cycles, stall low:
  - Expected: id_valid=0 and opcode=0 for those cycles; imem_addr stays constant.
- branch_taken with branch_target=64'h103 while stalled and imem_valid=1:
  - Expected: next cycle id_valid=0, imem_addr=64'h100, skid empty, fetch_count unchanged.
- rst_n pulsed low mid-HOLD:
  - Expected: all outputs return to reset values asynchronously; fetch resumes at RESET_PC.
- Start at pc=64'hFFFF_FFFF_FFFF_FFFC:
  - Expected: next imem_addr=0.
- Preload fetch_count to all-ones via 2^CNT_WIDTH fetches (or CNT_WIDTH=4 build):
  - Expected: count wraps to 0.
